// File: rtl/fetch_ctrl_if.sv
// Fetch sequencer control/status bundle between the core (master) and fetch_ctrl (slave).
// instr_count exists only when FETCH_COUNT_EN is defined.
interface fetch_ctrl_if #(
   parameter int A = 10
) ();
   logic         start;
   logic         stall;
   logic         halt;
   logic         jump_en;
   logic [A-1:0] jump_target;
   logic         branch_taken;
   logic [A-1:0] branch_offset;
   logic [A-1:0] instr_address;
   logic         running;
   logic         done;
   logic         wrap_err;
`ifdef FETCH_COUNT_EN
   logic [31:0]  instr_count;
`endif

   modport master (
      output start, stall, halt, jump_en, jump_target, branch_taken, branch_offset,
      input  instr_address, running, done, wrap_err
`ifdef FETCH_COUNT_EN
      , input instr_count
`endif
   );

   modport slave (
      input  start, stall, halt, jump_en, jump_target, branch_taken, branch_offset,
      output instr_address, running, done, wrap_err
`ifdef FETCH_COUNT_EN
      , output instr_count
`endif
   );
endinterface

// File: rtl/fetch_ctrl.sv
// Program counter and IDLE/RUN/DONE fetch sequencer feeding a combinational instruction ROM.
// Optional retired-instruction counter enabled by defining FETCH_COUNT_EN.
module fetch_ctrl #(
   parameter int           A          = 10,
   parameter logic [A-1:0] START_ADDR = {A{1'b0}}
) (
   input  logic       clk,
   input  logic       reset,
   fetch_ctrl_if.slave bus
);
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [A-1:0] PC_MAX = {A{1'b1}};
   localparam logic [A-1:0] PC_ONE = {{(A-1){1'b0}}, 1'b1};

   logic [1:0]   state_q, state_d;
   logic [A-1:0] pc_q, pc_d;
   logic         running_q, running_d;
   logic         done_q, done_d;
   logic         wrap_err_q, wrap_err_d;
   logic         launch_s;
   logic         retire_s;

   // Next-state and next-PC selection; in RUN exactly one PC source wins per edge.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      wrap_err_d = wrap_err_q;
      launch_s   = 1'b0;
      retire_s   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               state_d  = ST_RUN;
               pc_d     = START_ADDR;
               launch_s = 1'b1;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (bus.stall) begin
               pc_d = pc_q;
            end else if (bus.halt) begin
               state_d  = ST_DONE;
               retire_s = 1'b1;
            end else if (bus.jump_en) begin
               pc_d     = bus.jump_target;
               retire_s = 1'b1;
            end else if (bus.branch_taken) begin
               pc_d     = pc_q + bus.branch_offset;
               retire_s = 1'b1;
            end else if (pc_q == PC_MAX) begin
               // Sequential fall-off the top of the ROM ends the program rather than wrapping.
               state_d    = ST_DONE;
               wrap_err_d = 1'b1;
               retire_s   = 1'b1;
            end else begin
               pc_d     = pc_q + PC_ONE;
               retire_s = 1'b1;
            end
         end
         ST_DONE: begin
            if (bus.start) begin
               state_d    = ST_RUN;
               pc_d       = START_ADDR;
               wrap_err_d = 1'b0;
               launch_s   = 1'b1;
            end else begin
               state_d = ST_DONE;
            end
         end
         default: begin
            state_d    = ST_IDLE;
            pc_d       = START_ADDR;
            wrap_err_d = 1'b0;
         end
      endcase
      running_d = (state_d == ST_RUN);
      done_d    = (state_d == ST_DONE);
   end

   // Sequencer state and registered status flags.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         pc_q       <= START_ADDR;
         running_q  <= 1'b0;
         done_q     <= 1'b0;
         wrap_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         running_q  <= running_d;
         done_q     <= done_d;
         wrap_err_q <= wrap_err_d;
      end
   end

   assign bus.instr_address = pc_q;
   assign bus.running       = running_q;
   assign bus.done          = done_q;
   assign bus.wrap_err      = wrap_err_q;

`ifdef FETCH_COUNT_EN
   logic [31:0] count_q, count_d;

   // Saturating retired-instruction count, cleared on every launch.
   always_comb begin
      if (launch_s) begin
         count_d = 32'd0;
      end else if (retire_s && (count_q != 32'hFFFF_FFFF)) begin
         count_d = count_q + 32'd1;
      end else begin
         count_d = count_q;
      end
   end

   // Retired-instruction counter register.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= 32'd0;
      end else begin
         count_q <= count_d;
      end
   end

   assign bus.instr_count = count_q;
`else
   logic unused_s;
   assign unused_s = launch_s ^ retire_s;
`endif
endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed, table-driven bench for fetch_ctrl with hand sequences for reset and counter cases.
module tb_fetch_ctrl;
   localparam int A = 10;

   typedef struct {
      logic         start;
      logic         stall;
      logic         halt;
      logic         jump_en;
      logic [A-1:0] jump_target;
      logic         branch_taken;
      logic [A-1:0] branch_offset;
      logic [A-1:0] exp_addr;
      logic         exp_running;
      logic         exp_done;
      logic         exp_wrap;
   } vec_t;

   logic clk;
   logic reset;
   int   n_chk;
   int   n_fail;
   vec_t vecs[25];

   fetch_ctrl_if #(.A(A)) bus ();

   fetch_ctrl #(.A(A), .START_ADDR(10'd0)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(input logic st, input logic sl, input logic hl, input logic je,
                               input logic [A-1:0] jt, input logic bt, input logic [A-1:0] bo,
                               input logic [A-1:0] ea, input logic er, input logic ed,
                               input logic ew);
      vec_t v;
      v.start = st; v.stall = sl; v.halt = hl; v.jump_en = je; v.jump_target = jt;
      v.branch_taken = bt; v.branch_offset = bo;
      v.exp_addr = ea; v.exp_running = er; v.exp_done = ed; v.exp_wrap = ew;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic drive(input logic st, input logic sl, input logic hl, input logic je,
                        input logic [A-1:0] jt, input logic bt, input logic [A-1:0] bo);
      bus.start = st; bus.stall = sl; bus.halt = hl; bus.jump_en = je;
      bus.jump_target = jt; bus.branch_taken = bt; bus.branch_offset = bo;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_step();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 1'b0, 10'd0);
   endtask

   task automatic chk_all(input string nm, input logic [A-1:0] ea, input logic er,
                          input logic ed, input logic ew);
      chk({nm, "_addr"}, 32'(bus.instr_address), 32'(ea));
      chk({nm, "_running"}, 32'(bus.running), 32'(er));
      chk({nm, "_done"}, 32'(bus.done), 32'(ed));
      chk({nm, "_wrap"}, 32'(bus.wrap_err), 32'(ew));
   endtask

   initial begin
      n_chk  = 0;
      n_fail = 0;
      //            st    sl    hl    je    jt       bt    bo         addr     run   done  wrap
      vecs[0]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 10'd0,   1'b0, 10'd0,     10'd0,   1'b1, 1'b0, 1'b0);
      vecs[1]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 10'd0,   1'b0, 10'd0,     10'd1,   1'b1, 1'b0, 1'b0);
      vecs[2]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 10'd0,   1'b0, 10'd0,     10'd2,   1'b1, 1'b0, 1'b0);
      vecs[3]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 10'd0,   1'b0, 10'd0,     10'd3,   1'b1, 1'b0, 1'b0);
      vecs[4]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 10'd0,   1'b0, 10'd0,     10'd4,   1'b1, 1'b0, 1'b0);
      vecs[5]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 10'd0,   1'b0, 10'd0,     10'd5,   1'b1, 1'b0, 1'b0);
      vecs[6]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 10'd0,   1'b0, 10'd0,     10'd6,   1'b1, 1'b0, 1'b0);
      vecs[7]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 10'd0,   1'b0, 10'd0,     10'd7,   1'b1, 1'b0, 1'b0);
      vecs[8]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 10'd0,   1'b1, 10'h3FE,   10'd5,   1'b1, 1'b0, 1'b0);
      vecs[9]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 10'd0,   1'b0, 10'd0,     10'd0,   1'b1, 1'b0, 1'b0);
      vecs[10] = mk(1'b0, 1'b0, 1'b0, 1'b0, 10'd0,   1'b1, 10'h3FF,   10'd1023,1'b1, 1'b0, 1'b0);
      vecs[11] = mk(1'b0, 1'b0, 1'b0, 1'b1, 10'd4,   1'b0, 10'd0,     10'd4,   1'b1, 1'b0, 1'b0);
      vecs[12] = mk(1'b0, 1'b0, 1'b0, 1'b1, 10'd200, 1'b1, 10'd5,     10'd200, 1'b1, 1'b0, 1'b0);
      vecs[13] = mk(1'b0, 1'b1, 1'b1, 1'b1, 10'd7,   1'b0, 10'd0,     10'd200, 1'b1, 1'b0, 1'b0);
      vecs[14] = mk(1'b1, 1'b0, 1'b0, 1'b1, 10'd9,   1'b0, 10'd0,     10'd9,   1'b1, 1'b0, 1'b0);
      vecs[15] = mk(1'b0, 1'b0, 1'b1, 1'b0, 10'd0,   1'b0, 10'd0,     10'd9,   1'b0, 1'b1, 1'b0);
      vecs[16] = mk(1'b0, 1'b0, 1'b0, 1'b1, 10'd77,  1'b0, 10'd0,     10'd9,   1'b0, 1'b1, 1'b0);
      vecs[17] = mk(1'b0, 1'b0, 1'b0, 1'b0, 10'd0,   1'b1, 10'd3,     10'd9,   1'b0, 1'b1, 1'b0);
      vecs[18] = mk(1'b0, 1'b0, 1'b0, 1'b0, 10'd0,   1'b0, 10'd0,     10'd9,   1'b0, 1'b1, 1'b0);
      vecs[19] = mk(1'b1, 1'b0, 1'b0, 1'b0, 10'd0,   1'b0, 10'd0,     10'd0,   1'b1, 1'b0, 1'b0);
      vecs[20] = mk(1'b0, 1'b0, 1'b0, 1'b1, 10'd1023,1'b0, 10'd0,     10'd1023,1'b1, 1'b0, 1'b0);
      vecs[21] = mk(1'b0, 1'b0, 1'b0, 1'b0, 10'd0,   1'b0, 10'd0,     10'd1023,1'b0, 1'b1, 1'b1);
      vecs[22] = mk(1'b0, 1'b0, 1'b0, 1'b0, 10'd0,   1'b0, 10'd0,     10'd1023,1'b0, 1'b1, 1'b1);
      vecs[23] = mk(1'b1, 1'b0, 1'b0, 1'b0, 10'd0,   1'b0, 10'd0,     10'd0,   1'b1, 1'b0, 1'b0);
      vecs[24] = mk(1'b0, 1'b0, 1'b0, 1'b1, 10'd50,  1'b0, 10'd0,     10'd50,  1'b1, 1'b0, 1'b0);

      reset = 1'b1;
      idle_step();
      idle_step();
      chk_all("reset", 10'd0, 1'b0, 1'b0, 1'b0);
      reset = 1'b0;
      idle_step();
      chk_all("idle_hold", 10'd0, 1'b0, 1'b0, 1'b0);

      for (int i = 0; i < 25; i++) begin
         drive(vecs[i].start, vecs[i].stall, vecs[i].halt, vecs[i].jump_en,
               vecs[i].jump_target, vecs[i].branch_taken, vecs[i].branch_offset);
         chk_all($sformatf("v%0d", i), vecs[i].exp_addr, vecs[i].exp_running,
                 vecs[i].exp_done, vecs[i].exp_wrap);
      end

      // Reset mid-RUN at PC=50 beats a simultaneous start and jump.
      reset = 1'b1;
      drive(1'b1, 1'b0, 1'b0, 1'b1, 10'd300, 1'b0, 10'd0);
      chk_all("reset_mid_run", 10'd0, 1'b0, 1'b0, 1'b0);
      reset = 1'b0;
      idle_step();
      chk_all("post_reset_idle", 10'd0, 1'b0, 1'b0, 1'b0);

      // Sticky wrap_err cleared by reset while in DONE.
      drive(1'b1, 1'b0, 1'b0, 1'b0, 10'd0, 1'b0, 10'd0);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 10'd1023, 1'b0, 10'd0);
      idle_step();
      chk_all("wrap_done", 10'd1023, 1'b0, 1'b1, 1'b1);
      reset = 1'b1;
      idle_step();
      chk_all("reset_in_done", 10'd0, 1'b0, 1'b0, 1'b0);
      reset = 1'b0;

`ifdef FETCH_COUNT_EN
      drive(1'b1, 1'b0, 1'b0, 1'b0, 10'd0, 1'b0, 10'd0);
      chk("cnt_launch", bus.instr_count, 32'd0);
      for (int i = 0; i < 6; i++) idle_step();
      chk("cnt_six", bus.instr_count, 32'd6);
      drive(1'b0, 1'b1, 1'b0, 1'b0, 10'd0, 1'b0, 10'd0);
      drive(1'b0, 1'b1, 1'b0, 1'b0, 10'd0, 1'b0, 10'd0);
      chk("cnt_stall", bus.instr_count, 32'd6);
      drive(1'b0, 1'b0, 1'b1, 1'b0, 10'd0, 1'b0, 10'd0);
      chk("cnt_halt", bus.instr_count, 32'd7);
      chk("cnt_halt_done", 32'(bus.done), 32'd1);
      idle_step();
      chk("cnt_done_hold", bus.instr_count, 32'd7);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 10'd0, 1'b0, 10'd0);
      chk("cnt_relaunch", bus.instr_count, 32'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
